cla_seq_addsub: RTL and testbench

Multi-cycle, parametrised carry-lookahead add/subtract/logic unit for the ALU datapath. It generalises the first-level propagate/generate stage. Operand B is conditionally inverted by operation code, and per-bit p = A|B' and g = A&B' are formed as before. This block then evaluates the word one chunk of CLA groups per clock, chaining the carry between chunks, and presents a registered result with flags behind a valid/ready handshake. The ALU uses it where a full-width single-cycle CLA would not close timing.

---
 rtl/cla_seq_addsub.sv | 122 ++++++++++++
 tb/tb_cla_seq_addsub.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_addsub.sv
// cla_seq_addsub: multi-cycle carry-lookahead add/sub/logic unit with a valid/ready handshake.
// The word is evaluated one chunk of GPC groups (GROUP bits each) per clock.
// The carry is registered between chunks.
// Ports:
//   clk, reset             : clock (rising edge) and asynchronous active-high reset
//   in_valid, in_ready     : operand handshake; in_ready is high only in IDLE
//   bit1, bit2, Alu_Op     : operands A, B and op (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, others ADD)
//   out_valid, out_ready   : result handshake; outputs are held while out_valid is high
//   result, carry_out, overflow, zero : registered result and flags
// Optional feature: define CLA_SEQ_SLT_EN to make op 111 a set-less-than.
// Without it, op 111 behaves as SUB.
module cla_seq_addsub #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4,
   parameter int GPC   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] bit1,
   input  logic [WIDTH-1:0] bit2,
   input  logic [2:0]       Alu_Op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);
   localparam int C  = GROUP * GPC;
   localparam int N  = WIDTH / C;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a, b, res_full, res_final;
   logic [2:0]       op;
   logic [KW-1:0]    k;
   logic             cin, is_sub, is_and, is_or, is_slt, last, ov, gg, gp;
   logic [C-1:0]     ac, bc, p, g, s, chunk;
   logic [C:0]       cv;
   logic [GPC:0]     gc;
   assign is_sub = (op == 3'b110) || (op == 3'b111);
   assign is_and = op == 3'b000;
   assign is_or  = op == 3'b001;
   assign last   = k == KW'(N - 1);
`ifdef CLA_SEQ_SLT_EN
   assign is_slt = op == 3'b111;
`else
   assign is_slt = 1'b0;
`endif
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      state_nx  = state == IDLE ? (in_valid ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) :
                                  (out_ready ? IDLE : DONE);
   end
   // Chunk datapath.
   // Group generate/propagate are used to hop the carry across groups from the chunk carry-in.
   // Carries inside each group are then formed from that group's carry-in.
   always_comb begin
      ac = a[k*C +: C];
      bc = is_sub ? ~b[k*C +: C] : b[k*C +: C];
      p  = ac | bc;
      g  = ac & bc;
      gc = '0;
      cv = '0;
      gg = 1'b0;
      gp = 1'b1;
      gc[0] = cin;
      for (int i = 0; i < GPC; i++) begin
         gg = 1'b0;
         gp = 1'b1;
         for (int j = 0; j < GROUP; j++) begin
            gg = g[i*GROUP+j] | (p[i*GROUP+j] & gg);
            gp = gp & p[i*GROUP+j];
         end
         gc[i+1] = gg | (gp & gc[i]);
         cv[i*GROUP] = gc[i];
         for (int j = 0; j < GROUP - 1; j++)
            cv[i*GROUP+j+1] = g[i*GROUP+j] | (p[i*GROUP+j] & cv[i*GROUP+j]);
      end
      cv[C] = gc[GPC];
      s = ac ^ bc ^ cv[C-1:0];
      chunk = is_and ? g : is_or ? p : s;
      res_full = result;
      res_full[k*C +: C] = chunk;
      ov = cv[C] ^ cv[C-1];
      res_final = is_slt ? {{(WIDTH-1){1'b0}}, res_full[WIDTH-1] ^ ov} : res_full;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         a         <= '0;
         b         <= '0;
         op        <= '0;
         k         <= '0;
         cin       <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a   <= bit1;
         b   <= bit2;
         op  <= Alu_Op;
         k   <= '0;
         cin <= (Alu_Op == 3'b110) || (Alu_Op == 3'b111);
      end else if (state == RUN) begin
         cin <= cv[C];
         k   <= last ? '0 : k + 1'b1;
         result <= last ? res_final : res_full;
         if (last) begin
            carry_out <= (is_and || is_or) ? 1'b0 : cv[C];
            overflow  <= (is_and || is_or) ? 1'b0 : ov;
            zero      <= res_final == '0;
         end
      end
endmodule

// File: tb/tb_cla_seq_addsub.sv
// tb_cla_seq_addsub: directed self-checking bench for cla_seq_addsub at default parameters.
module tb_cla_seq_addsub;
   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] bit1, bit2, result;
   logic [2:0]  Alu_Op;
   logic        carry_out, overflow, zero;
   int          tests = 0;
   int          fails = 0;

   cla_seq_addsub dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .bit1(bit1), .bit2(bit2), .Alu_Op(Alu_Op), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .carry_out(carry_out),
      .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   // Presents one operation for a single accept edge, then counts edges until out_valid.
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o, output int lat);
      @(negedge clk);
      bit1 = x;
      bit2 = y;
      Alu_Op = o;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) break;
      end
      tests++;
      if (!out_valid) begin
         fails++;
         $display("FAIL op_timeout out_valid=%b after %0d clocks, required 1", out_valid, lat);
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL consume out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h required %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      bit1 = '0;
      bit2 = '0;
      Alu_Op = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_flags", {29'b0, carry_out, overflow, zero}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add();
      int lat;
      do_op(32'h7FFFFFFF, 32'h00000001, 3'b010, lat);
      chk("add_ovf_latency", lat, 32'd4);
      chk("add_ovf_result", result, 32'h80000000);
      chk("add_ovf_flags", {29'b0, carry_out, overflow, zero}, 32'b010);
      consume();
      do_op(32'hFFFFFFFF, 32'h00000001, 3'b010, lat);
      chk("add_wrap_result", result, 32'h0);
      chk("add_wrap_flags", {29'b0, carry_out, overflow, zero}, 32'b101);
      consume();
      do_op(32'd2, 32'd3, 3'b011, lat);
      chk("op011_as_add", result, 32'd5);
      consume();
   endtask

   task automatic test_sub();
      int lat;
      do_op(32'h0, 32'h1, 3'b110, lat);
      chk("sub_borrow_result", result, 32'hFFFFFFFF);
      chk("sub_borrow_flags", {29'b0, carry_out, overflow, zero}, 32'b000);
      consume();
      do_op(32'd5, 32'd5, 3'b110, lat);
      chk("sub_eq_result", result, 32'h0);
      chk("sub_eq_flags", {29'b0, carry_out, overflow, zero}, 32'b101);
      consume();
   endtask

   task automatic test_logic_hold();
      int lat;
      do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, lat);
      chk("and_result", result, 32'hF000F000);
      chk("and_flags", {29'b0, carry_out, overflow, zero}, 32'b000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         bit1 = 32'h12345678;
         bit2 = 32'h1;
         Alu_Op = 3'b010;
         @(posedge clk);
         #1;
         chk("hold_result", result, 32'hF000F000);
         chk("hold_hs", {30'b0, out_valid, in_ready}, 32'b10);
      end
      @(negedge clk);
      in_valid = 1'b0;
      consume();
      do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b001, lat);
      chk("or_result", result, 32'hFFF0FFF0);
      chk("or_flags", {29'b0, carry_out, overflow, zero}, 32'b000);
      consume();
   endtask

   task automatic test_reset_midflight();
      int lat;
      @(negedge clk);
      bit1 = 32'hFFFFFFFF;
      bit2 = 32'hFFFFFFFF;
      Alu_Op = 3'b010;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_hs", {30'b0, out_valid, in_ready}, 32'b01);
      @(negedge clk);
      reset = 1'b0;
      do_op(32'd3, 32'd4, 3'b010, lat);
      chk("post_rst_add", result, 32'd7);
      chk("post_rst_flags", {29'b0, carry_out, overflow, zero}, 32'b000);
      consume();
   endtask

   task automatic test_slt();
      int lat;
      do_op(32'hFFFFFFFD, 32'h00000002, 3'b111, lat);
`ifdef CLA_SEQ_SLT_EN
      chk("slt_result", result, 32'd1);
`else
      chk("slt_as_sub_result", result, 32'hFFFFFFFB);
`endif
      chk("slt_flags", {29'b0, carry_out, overflow, zero}, 32'b100);
      consume();
   endtask

   task automatic test_back_to_back();
      int lat;
      do_op(32'h00000010, 32'h00000020, 3'b010, lat);
      chk("b2b_first", result, 32'h30);
      consume();
      do_op(32'h80000000, 32'h80000000, 3'b010, lat);
      chk("b2b_second_latency", lat, 32'd4);
      chk("b2b_second", result, 32'h0);
      chk("b2b_second_flags", {29'b0, carry_out, overflow, zero}, 32'b111);
      consume();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic_hold();
      test_reset_midflight();
      test_slt();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
